// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op classes, R-type funct
// codes, the MDU sequencer states and the default datapath width.
package ex_pkg;
    localparam int XLEN_DEF = 32;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_SLTI  = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // mult/multu/div/divu share funct[5:2] = 0110; funct[1] = div, funct[0] = unsigned.
    function automatic logic is_mdu(input logic [1:0] op, input logic [5:0] fn);
        return (op == ALU_RTYPE) && (fn[5:2] == 4'b0110);
    endfunction
endpackage

// File: rtl/ex_mdu.sv
// Iterative multiply/divide: XLEN shift-add or restoring steps on operand
// magnitudes, with sign fix-up and divide-by-zero handling on the way out.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_den, r_a;
    logic              r_div, r_neg_q, r_neg_r;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_q, w_r;
    logic [XLEN:0]     w_madd, w_rsh, w_dsub;
    logic [2*XLEN-1:0] w_prod;

    assign w_a_neg = !i_op[0] && i_a[XLEN-1];
    assign w_b_neg = !i_op[0] && i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // r_acc is {partial product, multiplier} for mult and {remainder, quotient} for div.
    assign w_madd = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_den} : '0);
    assign w_rsh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_dsub = w_rsh - {1'b0, r_den};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_den   <= '0;
            r_a     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_cnt   <= CW'(XLEN);
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_den   <= w_b_mag;
            r_a     <= i_a;
            r_div   <= i_op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_div)
                r_acc <= {w_dsub[XLEN] ? w_rsh[XLEN-1:0] : w_dsub[XLEN-1:0],
                          r_acc[XLEN-2:0], !w_dsub[XLEN]};
            else
                r_acc <= {w_madd, r_acc[XLEN-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_q    = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r    = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign o_last = (r_cnt == CW'(1));

    always_comb begin
        o_hi = w_prod[2*XLEN-1:XLEN];
        o_lo = w_prod[XLEN-1:0];
        if (r_div) begin
            if (r_den == '0) begin
                o_hi = r_a;
                o_lo = '1;
            end else begin
                o_hi = w_r;
                o_lo = w_q;
            end
        end
    end
endmodule

// File: rtl/ex_stage_pipe.sv
// MIPS execute stage: ALU, branch target/decision, HI/LO with an iterative MDU,
// and the handshaked EX/MEM output register.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int BR_SHIFT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic [XLEN-1:0] sign_ext,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    input  logic            branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_out,
    output logic            zero,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] pc_out,
    output logic            take_branch,
    output logic            busy
);
    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_hi, r_lo, r_result, r_address, r_pc, r_op_pc, r_op_addr;
    logic            r_out_valid, r_zero, r_take, r_op_br;
    logic [XLEN-1:0] w_b, w_target, w_alu, w_mdu_hi, w_mdu_lo;
    logic [4:0]      w_shamt;
    logic            w_mdu_op, w_acc, w_slot_free, w_mdu_start, w_alu_load, w_mdu_load, w_mdu_last;

    assign w_b         = alu_src ? sign_ext : rt;
    assign w_target    = pc + (sign_ext << BR_SHIFT);
    assign w_shamt     = 5'(sign_ext >> 6);
    assign w_mdu_op    = is_mdu(alu_op, funct);
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = reset && (r_state == S_IDLE) && w_slot_free;
    assign busy        = (r_state != S_IDLE);
    assign w_acc       = in_valid && in_ready;
    assign w_mdu_start = w_acc && w_mdu_op;
    assign w_alu_load  = w_acc && !w_mdu_op;
    assign w_mdu_load  = (r_state == S_DONE) && w_slot_free;

    always_comb begin
        w_alu = '0;
        case (alu_op)
            ALU_ADD:  w_alu = rs + w_b;
            ALU_SUB:  w_alu = rs - w_b;
            ALU_SLTI: w_alu = {{(XLEN-1){1'b0}}, $signed(rs) < $signed(w_b)};
            default: begin
                case (funct)
                    F_ADD:  w_alu = rs + w_b;
                    F_SUB:  w_alu = rs - w_b;
                    F_AND:  w_alu = rs & w_b;
                    F_OR:   w_alu = rs | w_b;
                    F_XOR:  w_alu = rs ^ w_b;
                    F_NOR:  w_alu = ~(rs | w_b);
                    F_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs) < $signed(w_b)};
                    F_SLTU: w_alu = {{(XLEN-1){1'b0}}, rs < w_b};
                    F_SLL:  w_alu = rt << w_shamt;
                    F_SRL:  w_alu = rt >> w_shamt;
                    F_SRA:  w_alu = $signed(rt) >>> w_shamt;
                    F_MFHI: w_alu = r_hi;
                    F_MFLO: w_alu = r_lo;
                    default: w_alu = '0;
                endcase
            end
        endcase
    end

    ex_mdu #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_mdu_start),
        .i_op   (funct[1:0]),
        .i_a    (rs),
        .i_b    (rt),
        .o_last (w_mdu_last),
        .o_hi   (w_mdu_hi),
        .o_lo   (w_mdu_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mdu_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_mdu_last)  w_state_nxt = S_DONE;
            S_DONE:  if (w_slot_free) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An MDU op keeps its pc/target/branch bits here until its result lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0; r_lo <= '0;
            r_op_pc <= '0; r_op_addr <= '0; r_op_br <= 1'b0;
            r_out_valid <= 1'b0; r_result <= '0; r_zero <= 1'b0;
            r_address <= '0; r_pc <= '0; r_take <= 1'b0;
        end else begin
            if (w_mdu_start) begin
                r_op_pc   <= pc;
                r_op_addr <= w_target;
                r_op_br   <= branch;
            end
            if (w_alu_load) begin
                r_out_valid <= 1'b1;
                r_result    <= w_alu;
                r_zero      <= (w_alu == '0);
                r_address   <= w_target;
                r_pc        <= pc;
                r_take      <= branch && (w_alu == '0);
            end else if (w_mdu_load) begin
                r_hi        <= w_mdu_hi;
                r_lo        <= w_mdu_lo;
                r_out_valid <= 1'b1;
                r_result    <= w_mdu_lo;
                r_zero      <= (w_mdu_lo == '0);
                r_address   <= r_op_addr;
                r_pc        <= r_op_pc;
                r_take      <= r_op_br && (w_mdu_lo == '0);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign result_out  = r_result;
    assign zero        = r_zero;
    assign address     = r_address;
    assign pc_out      = r_pc;
    assign take_branch = r_take;
endmodule
